// File: rtl/riscp_pkg.sv
// Shared types and widths for the 16-bit pipelined core.
package riscp_pkg;

   localparam int DW   = 16;
   localparam int RW   = 3;
   localparam int CNTW = 32;

   typedef logic [RW-1:0] reg_idx_t;
   typedef logic [DW-1:0] data_t;

   // r0 is hardwired to zero, so a write to it must never reach the register file
   localparam reg_idx_t REG_ZERO = '0;

   typedef enum logic [1:0] {
      RUN,
      HALT_PEND,
      HALTED
   } wb_state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: MEM-stage instruction fields in, writeback/forwarding/status out.
interface mem_wb_stage_if
   import riscp_pkg::*;
#(
   parameter int CNTW = 32
);

   logic            stall;
   logic            flush;
   logic            m_valid;
   logic            m_regwrite;
   logic            m_memtoreg;
   logic            m_halt;
   reg_idx_t        m_rd;
   data_t           m_alu_result;
   data_t           m_mem_rd;

   logic            wb_valid;
   logic            wb_we;
   reg_idx_t        wb_rd;
   data_t           wb_data;
   logic            fwd_en;
   reg_idx_t        fwd_rd;
   data_t           fwd_data;
   logic            halted;
   logic [CNTW-1:0] instret;

   // Pipeline side that feeds the stage and consumes its results
   modport master (
      output stall, flush, m_valid, m_regwrite, m_memtoreg, m_halt,
             m_rd, m_alu_result, m_mem_rd,
      input  wb_valid, wb_we, wb_rd, wb_data, fwd_en, fwd_rd, fwd_data,
             halted, instret
   );

   // The MEM/WB stage itself
   modport slave (
      input  stall, flush, m_valid, m_regwrite, m_memtoreg, m_halt,
             m_rd, m_alu_result, m_mem_rd,
      output wb_valid, wb_we, wb_rd, wb_data, fwd_en, fwd_rd, fwd_data,
             halted, instret
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts on en, freezes on hold, sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         hold,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: hold wins over en; never wrap past all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (!hold && en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, writeback select, forwarding and halt control.
module mem_wb_stage
   import riscp_pkg::*;
#(
   parameter int CNTW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_wb_stage_if.slave bus
);

   wb_state_t state_q;
   logic      valid_q;
   logic      we_q;
   reg_idx_t  rd_q;
   data_t     data_q;
   logic      halted_q;

   data_t     sel_d;
   logic      capture_d;
   logic      we_d;
   logic      cnt_en_d;
   logic      cnt_hold_d;

   // Writeback select happens before the register so only one value is stored
   assign sel_d = bus.m_memtoreg ? bus.m_mem_rd : bus.m_alu_result;

   // A normal capture only happens while running with neither flush nor stall
   assign capture_d = (state_q == RUN) && !bus.flush && !bus.stall;

   // HALT never writes a register, and r0 is never written
   assign we_d = bus.m_regwrite && !bus.m_halt && (bus.m_rd != REG_ZERO);

   // Retire count: one per captured valid instruction, HALT included
   assign cnt_en_d   = capture_d && bus.m_valid;
   assign cnt_hold_d = !capture_d;

   // WB register and halt FSM; priority is reset > halted > flush > stall > capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         valid_q  <= 1'b0;
         we_q     <= 1'b0;
         rd_q     <= REG_ZERO;
         data_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            HALTED: begin
               // Absorbing: WB keeps the bubble loaded on entry
               halted_q <= 1'b1;
            end
            HALT_PEND: begin
               // HALT has had its cycle in WB; retire it and freeze
               state_q  <= HALTED;
               halted_q <= 1'b1;
               valid_q  <= 1'b0;
               we_q     <= 1'b0;
               rd_q     <= REG_ZERO;
               data_q   <= '0;
            end
            default: begin
               if (bus.flush) begin
                  // Flush beats stall and also drops a HALT sitting in MEM
                  valid_q <= 1'b0;
                  we_q    <= 1'b0;
                  rd_q    <= REG_ZERO;
                  data_q  <= '0;
               end else if (bus.stall) begin
                  valid_q <= valid_q;
               end else if (bus.m_valid) begin
                  valid_q <= 1'b1;
                  we_q    <= we_d;
                  rd_q    <= bus.m_rd;
                  data_q  <= sel_d;
                  if (bus.m_halt) begin
                     state_q  <= HALT_PEND;
                     halted_q <= 1'b1;
                  end
               end else begin
                  valid_q <= 1'b0;
                  we_q    <= 1'b0;
                  rd_q    <= REG_ZERO;
                  data_q  <= '0;
               end
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNTW)
   ) u_instret (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cnt_en_d),
      .hold  (cnt_hold_d),
      .q     (bus.instret)
   );

   assign bus.wb_valid = valid_q;
   assign bus.wb_we    = we_q;
   assign bus.wb_rd    = rd_q;
   assign bus.wb_data  = data_q;
   assign bus.fwd_en   = we_q;
   assign bus.fwd_rd   = rd_q;
   assign bus.fwd_data = data_q;
   assign bus.halted   = halted_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios then random traffic against a behavioural model.
module tb_mem_wb_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        t_stall, t_flush, t_valid, t_regwrite, t_memtoreg, t_halt;
   logic [2:0]  t_rd;
   logic [15:0] t_alu, t_mem;

   mem_wb_stage_if #(.CNTW(32)) bus  ();
   mem_wb_stage_if #(.CNTW(4))  bus4 ();

   assign bus.stall         = t_stall;
   assign bus.flush         = t_flush;
   assign bus.m_valid       = t_valid;
   assign bus.m_regwrite    = t_regwrite;
   assign bus.m_memtoreg    = t_memtoreg;
   assign bus.m_halt        = t_halt;
   assign bus.m_rd          = t_rd;
   assign bus.m_alu_result  = t_alu;
   assign bus.m_mem_rd      = t_mem;
   assign bus4.stall        = t_stall;
   assign bus4.flush        = t_flush;
   assign bus4.m_valid      = t_valid;
   assign bus4.m_regwrite   = t_regwrite;
   assign bus4.m_memtoreg   = t_memtoreg;
   assign bus4.m_halt       = t_halt;
   assign bus4.m_rd         = t_rd;
   assign bus4.m_alu_result = t_alu;
   assign bus4.m_mem_rd     = t_mem;

   mem_wb_stage #(.CNTW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   mem_wb_stage #(.CNTW(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   // Reference model: what WB should hold, how far the halt has progressed, how many retired
   bit          e_valid, e_we;
   logic [2:0]  e_rd;
   logic [15:0] e_data;
   int          halt_phase;   // 0 running, 1 HALT in WB, 2 frozen
   int          retired;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic bubble();
      e_valid = 0; e_we = 0; e_rd = '0; e_data = '0;
   endtask

   // Drive one cycle of inputs, advance the model over the edge, compare all outputs
   task automatic step(input bit rn, input bit st, input bit fl, input bit v, input bit rw,
                       input bit mt, input bit h, input logic [2:0] rd,
                       input logic [15:0] alu, input logic [15:0] mem, input string tag);
      rst_n = rn; t_stall = st; t_flush = fl; t_valid = v; t_regwrite = rw;
      t_memtoreg = mt; t_halt = h; t_rd = rd; t_alu = alu; t_mem = mem;
      @(posedge clk);
      if (!rn) begin
         bubble(); halt_phase = 0; retired = 0;
      end else if (halt_phase == 2) begin
         // everything ignored
      end else if (halt_phase == 1) begin
         bubble(); halt_phase = 2;
      end else if (fl) begin
         bubble();
      end else if (st) begin
         // hold
      end else if (v) begin
         e_valid = 1;
         e_rd    = rd;
         e_data  = mt ? mem : alu;
         e_we    = rw && !h && (rd != 3'd0);
         retired++;
         if (h) halt_phase = 1;
      end else begin
         bubble();
      end
      #1;
      $display("cyc %s rst_n=%0b st=%0b fl=%0b v=%0b h=%0b rd=%0d -> valid=%0b we=%0b rd=%0d data=%h halted=%0b instret=%0d",
               tag, rn, st, fl, v, h, rd, bus.wb_valid, bus.wb_we, bus.wb_rd, bus.wb_data,
               bus.halted, bus.instret);
      check({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(e_valid));
      check({tag, ".wb_we"},    64'(bus.wb_we),    64'(e_we));
      check({tag, ".wb_rd"},    64'(bus.wb_rd),    64'(e_rd));
      check({tag, ".wb_data"},  64'(bus.wb_data),  64'(e_data));
      check({tag, ".fwd_en"},   64'(bus.fwd_en),   64'(e_we));
      check({tag, ".fwd_rd"},   64'(bus.fwd_rd),   64'(e_rd));
      check({tag, ".fwd_data"}, 64'(bus.fwd_data), 64'(e_data));
      check({tag, ".halted"},   64'(bus.halted),   64'(halt_phase != 0));
      check({tag, ".instret"},  64'(bus.instret),  64'(retired));
      check({tag, ".instret4"}, 64'(bus4.instret), 64'((retired > 15) ? 15 : retired));
      check({tag, ".halted4"},  64'(bus4.halted),  64'(halt_phase != 0));
   endtask

   task automatic rnd_reset(input string tag);
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), tag);
   endtask

   initial begin
      e_valid = 0; e_we = 0; e_rd = '0; e_data = '0; halt_phase = 0; retired = 0;

      // Reset with random inputs on the bus
      rnd_reset("reset0");
      rnd_reset("reset1");

      // ALU writeback, then load writeback, then the same load to r0
      step(1, 0, 0, 1, 1, 0, 0, 3'd3, 16'h1234, 16'h5555, "alu_wb");
      step(1, 0, 0, 1, 1, 1, 0, 3'd5, 16'h0040, 16'hBEEF, "load_wb");
      step(1, 0, 0, 1, 1, 1, 0, 3'd0, 16'h0040, 16'hBEEF, "load_r0");

      // Capture, stall three cycles with changing inputs, then flush under stall
      step(1, 0, 0, 1, 1, 0, 0, 3'd2, 16'h00AA, 16'h0000, "cap_aa");
      for (int i = 0; i < 3; i++)
         step(1, 1, 0, 1, 1, 1'($urandom), 0, 3'($urandom), 16'($urandom), 16'($urandom), "stall");
      step(1, 1, 1, 1, 1, 0, 0, 3'd6, 16'h7777, 16'h8888, "flush_stall");

      // Flush beats a HALT in MEM
      step(1, 0, 1, 1, 1, 0, 1, 3'd4, 16'h0101, 16'h0202, "flush_halt");

      // HALT: captured, then frozen against 10 valid instructions, then reset
      step(1, 0, 0, 1, 1, 0, 1, 3'd4, 16'h0F0F, 16'h0000, "halt");
      for (int i = 0; i < 10; i++)
         step(1, 1'($urandom), 1'($urandom), 1, 1, 1'($urandom), 0, 3'd1 + 3'($urandom_range(0, 6)),
              16'($urandom), 16'($urandom), "halted");
      step(0, 0, 0, 1, 1, 0, 0, 3'd1, 16'h1111, 16'h0, "halt_reset");

      // Saturation: 20 captures drive the narrow counter to all-ones
      for (int i = 0; i < 20; i++)
         step(1, 0, 0, 1, 1'($urandom), 1'($urandom), 0, 3'($urandom), 16'($urandom), 16'($urandom), "sat");
      check("sat.instret4_final", 64'(bus4.instret), 64'hF);

      // Random traffic with occasional reset, halt, flush and stall
      for (int i = 0; i < 2500; i++) begin
         step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
              ($urandom_range(0, 99) < 80), 1'($urandom), 1'($urandom), ($urandom_range(0, 99) < 3),
              3'($urandom), 16'($urandom), 16'($urandom), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
